mips_mem_responder: RTL
=======================

MIPS_MEM_RESPONDER -- requirements
Module: mips_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, number of 32-bit storage words (power of two, 4..1024).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted per access (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder accepts a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  write data.
REQ-010 SHALL have port rsp_valid  output  1  response available.
REQ-011 SHALL have port rsp_ready  input  1  initiator consumes the response.
REQ-012 SHALL have port rsp_rdata  output  32  read data.
REQ-013 SHALL have port rsp_err  output  1  access faulted.
REQ-014 SHALL have port test  output  16  bits [15:0] of storage word 0, registered.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, RESP; req_ready = (state == IDLE); rsp_valid = (state == RESP).
REQ-016 SHALL, in IDLE on req_valid high, capture req_we, req_addr, req_wdata; go to RESP if WAIT_CYCLES = 0, else to BUSY with counter = WAIT_CYCLES-1.
REQ-017 SHALL, in BUSY, decrement counter each cycle and go to RESP on the cycle counter = 0.
REQ-018 SHALL perform the storage access on the edge entering RESP; rsp_valid rises WAIT_CYCLES+1 cycles after the accepting edge.
REQ-019 SHALL hold rsp_valid, rsp_rdata, rsp_err stable in RESP until rsp_ready is high, then return to IDLE on that edge.
REQ-020 SHALL ignore req_valid outside IDLE; at most one request outstanding.
REQ-021 SHALL index storage by req_addr[log2(DEPTH_WORDS)+1:2].
REQ-022 SHALL treat req_addr >= 4*DEPTH_WORDS as out of range: no write, rsp_rdata = 0, rsp_err = 1.
REQ-023 SHALL return rsp_rdata = 0 for writes; rsp_err = 0 for all in-range accesses unless REQ-030 applies.
REQ-024 SHALL update test on the same edge a write to word 0 commits.

Reset
REQ-025 SHALL, while reset is low, force state IDLE, counter 0, rsp_rdata 0, rsp_err 0, test 0, all storage words 0.
REQ-026 SHALL, on reset asserted mid-access (BUSY or RESP), discard the pending request; no write commits.
REQ-027 SHALL drive req_ready = 1 and rsp_valid = 0 during and immediately after reset.

Configuration
REQ-028 SHALL gate the alignment check with macro MEM_ALIGN_CHECK_EN.
REQ-029 SHALL, without MEM_ALIGN_CHECK_EN, ignore req_addr[1:0].
REQ-030 SHALL, with MEM_ALIGN_CHECK_EN, treat req_addr[1:0] != 0 as a fault: no write, rsp_rdata = 0, rsp_err = 1, same latency.

Structure
REQ-031 SHALL take the FSM state enum, data width (32) and test width (16) from shared package mips_mem_pkg.
REQ-032 SHALL place storage in one sub-module mips_mem_array (synchronous write, single port, async active-low clear); FSM and handshake stay in the top.

Verification
REQ-033 SHALL cover: write 0x0000_BEEF to addr 0x0 (WAIT_CYCLES=2), rsp_ready=1 -> rsp_valid on cycle 3 after accept, rsp_err 0, test = 0xBEEF.
REQ-034 SHALL cover: write 0x1234_5678 to 0x10, then read 0x10 -> rsp_rdata 0x1234_5678, rsp_err 0.
REQ-035 SHALL cover: read addr 0x100 with DEPTH_WORDS=64 -> rsp_rdata 0, rsp_err 1; no storage change.
REQ-036 SHALL cover: rsp_ready held low 5 cycles -> rsp_valid/rsp_rdata stable, req_ready 0, new req_valid ignored.
REQ-037 SHALL cover: reset pulled low in BUSY of a write to 0x4 -> after release, read 0x4 returns 0.
REQ-038 SHALL cover: read addr 0x2 -> rsp_err 1 with MEM_ALIGN_CHECK_EN; word 0 data, rsp_err 0 without.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and widths for the MIPS memory responder and its storage array.
package mips_mem_pkg;

    localparam int DATA_W = 32;
    localparam int TEST_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mips_mem_array.sv
// Single-port word storage with synchronous write, combinational read and async clear.
// Also keeps a registered copy of the low half of word 0 for board-level observation.
module mips_mem_array
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [TEST_W-1:0] test
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // The test register shadows word 0 so it changes on the very edge the write commits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
            test <= '0;
        end else if (we) begin
            mem[addr] <= wdata;
            if (addr == '0) begin
                test <= wdata[TEST_W-1:0];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mips_mem_responder.sv
// Wait-state memory responder with valid/ready request and response handshakes.
// Define MEM_ALIGN_CHECK_EN to fault accesses whose byte address is not word aligned.
module mips_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [TEST_W-1:0] test
);

    localparam int          ADDR_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT   = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);
    localparam logic        NO_WAIT    = (WAIT_CYCLES == 0);

    state_t            state;
    state_t            state_next;
    logic [3:0]        cnt;
    logic              cap_we;
    logic [31:0]       cap_addr;
    logic [DATA_W-1:0] cap_wdata;

    logic              accept;
    logic              enter_resp;
    logic              acc_we;
    logic [31:0]       acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              misalign;
    logic              fault;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    assign accept     = (state == IDLE) && req_valid;
    assign enter_resp = (accept && NO_WAIT) || ((state == BUSY) && (cnt == 4'd0));

    // With no wait states the access happens on the accepting edge, before capture.
    assign acc_we    = (state == IDLE) ? req_we    : cap_we;
    assign acc_addr  = (state == IDLE) ? req_addr  : cap_addr;
    assign acc_wdata = (state == IDLE) ? req_wdata : cap_wdata;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = |acc_addr[1:0];
`else
    assign misalign = 1'b0;
`endif

    assign fault  = (acc_addr >= ADDR_LIMIT) || misalign;
    assign mem_we = enter_resp && acc_we && !fault;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req_valid) state_next = NO_WAIT ? RESP : BUSY;
            BUSY: if (cnt == 4'd0) state_next = RESP;
            RESP: if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else if (accept) begin
            cnt       <= CNT_INIT;
            cap_we    <= req_we;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
        end else if ((state == BUSY) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Response registers load only when entering RESP and stay frozen until consumed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (enter_resp) begin
            rsp_err   <= fault;
            rsp_rdata <= (fault || acc_we) ? '0 : mem_rdata;
        end
    end

    mips_mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .ADDR_W     (ADDR_W)
    ) u_array (
        .clk  (clk),
        .reset(reset),
        .we   (mem_we),
        .addr (acc_addr[ADDR_W+1:2]),
        .wdata(acc_wdata),
        .rdata(mem_rdata),
        .test (test)
    );

endmodule
